// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam int unsigned PC_STEP          = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit bus: instruction-memory port, redirect input and decode-side handshake.
interface fetch_queue_unit_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned ILEN  = 32,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_pc_plus4;
   logic [ILEN-1:0] out_inst;
   logic [CW-1:0]   count;

   modport master (
      output imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_inst, count,
      input  imem_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_pc, out_pc_plus4, out_inst, count,
      output imem_rdata, redirect_valid, redirect_pc, out_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush (flush beats push), count and head read.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage is not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the PC, issues 1-cycle-latency imem reads, queues {pc, inst} toward decode.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int unsigned    XLEN     = 32,
   parameter int unsigned    ILEN     = 32,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst_n,
   fetch_queue_unit_if.master bus
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } entry_t;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_pc;
   logic            inflight;
   logic            started;
   logic            req;
   logic            pop;
   logic            fifo_empty;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   space;
   entry_t          head;
   entry_t          push_entry;
   logic            unused_pc_bits;

   assign unused_pc_bits = ^bus.redirect_pc[1:0];

   // Credit counts the in-flight read so the queue can never overflow.
   assign pop        = ~fifo_empty & bus.out_ready;
   assign space      = CW'(DEPTH) - cnt - CW'(inflight) + CW'(pop);
   assign req        = started & ~bus.redirect_valid & (space != '0);
   assign push_entry = '{pc: req_pc, inst: bus.imem_rdata};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
         started  <= 1'b0;
      end else begin
         started <= 1'b1;
         if (bus.redirect_valid) begin
            pc       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
         end else if (req) begin
            pc       <= pc + XLEN'(PC_STEP);
            req_pc   <= pc;
            inflight <= 1'b1;
         end else begin
            inflight <= 1'b0;
         end
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight & ~bus.redirect_valid),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (bus.redirect_valid),
      .head      (head),
      .count     (cnt),
      .empty     (fifo_empty)
   );

   assign bus.imem_req     = req;
   assign bus.imem_addr    = pc;
   assign bus.out_valid    = ~fifo_empty;
   assign bus.out_pc       = head.pc;
   assign bus.out_pc_plus4 = head.pc + XLEN'(PC_STEP);
   assign bus.out_inst     = fifo_empty ? ILEN'(NOP) : head.inst;
   assign bus.count        = cnt;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: cycle table, scoreboard, PC wrap and mid-stream reset.
module tb_fetch_queue_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic rst_w_n;
   logic wrap_done = 1'b0;

   fetch_queue_unit_if #(.XLEN(32), .ILEN(32), .DEPTH(4)) bus ();
   fetch_queue_unit_if #(.XLEN(32), .ILEN(32), .DEPTH(2)) bus_w ();

   fetch_queue_unit #(
      .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   fetch_queue_unit #(
      .XLEN(32), .ILEN(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)
   ) dut_w (
      .clk   (clk),
      .rst_n (rst_w_n),
      .bus   (bus_w.master)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Instruction memories: 1-cycle read latency, junk when not requested.
   always @(posedge clk) bus.imem_rdata   <= bus.imem_req   ? inst_of(bus.imem_addr)   : 32'hDEAD_BEEF;
   always @(posedge clk) bus_w.imem_rdata <= bus_w.imem_req ? inst_of(bus_w.imem_addr) : 32'hDEAD_BEEF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [31:0] sb_q [$];
   logic [31:0] model_pc;

   task automatic sb_step();
      if (bus.out_valid) begin
         chk("sb_valid_has_entry", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            chk("sb_out_pc", bus.out_pc, sb_q[0]);
            chk("sb_out_pc_plus4", bus.out_pc_plus4, sb_q[0] + 32'd4);
            chk("sb_out_inst", bus.out_inst, inst_of(sb_q[0]));
            if (bus.out_ready) void'(sb_q.pop_front());
         end
      end
      if (bus.redirect_valid) begin
         chk("sb_redirect_no_req", 32'(bus.imem_req), 32'd0);
         sb_q.delete();
         model_pc = bus.redirect_pc & ~32'h3;
      end else if (bus.imem_req) begin
         chk("sb_req_addr", bus.imem_addr, model_pc);
         sb_q.push_back(model_pc);
         model_pc = model_pc + 32'd4;
      end
   endtask

   task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
      bus.out_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
   endtask

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ov;
      logic [31:0] e_pc;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t tv [29];

   initial begin
      logic seen;
      // rdy rv rpc | req addr valid pc count ; row index = cycles after reset release
      tv[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h000, 1'b0, 32'h000, 3'd0};
      tv[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000, 3'd0};
      tv[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000, 3'd0};
      tv[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000, 3'd1};
      tv[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004, 3'd1};
      tv[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008, 3'd1};
      tv[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h014, 1'b1, 32'h00C, 3'd1};
      tv[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h018, 1'b1, 32'h010, 3'd1};
      tv[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h01C, 1'b1, 32'h014, 3'd1};
      tv[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b1, 32'h014, 3'd2};
      tv[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h024, 1'b1, 32'h014, 3'd3};
      tv[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h024, 1'b1, 32'h014, 3'd4};
      tv[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h024, 1'b1, 32'h014, 3'd4};
      tv[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h024, 1'b1, 32'h014, 3'd4};
      tv[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h028, 1'b1, 32'h018, 3'd3};
      tv[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h02C, 1'b1, 32'h01C, 3'd3};
      tv[16] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h030, 1'b1, 32'h020, 3'd3};
      tv[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h034, 1'b1, 32'h024, 3'd3};
      tv[18] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h038, 1'b1, 32'h028, 3'd3};
      tv[19] = '{1'b1, 1'b1, 32'h103, 1'b0, 32'h03C, 1'b1, 32'h02C, 3'd3};
      tv[20] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000, 3'd0};
      tv[21] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000, 3'd0};
      tv[22] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 3'd1};
      tv[23] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104, 3'd1};
      tv[24] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h110, 1'b1, 32'h108, 3'd1};
      tv[25] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h200, 1'b0, 32'h000, 3'd0};
      tv[26] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h000, 3'd0};
      tv[27] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h304, 1'b0, 32'h000, 3'd0};
      tv[28] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h308, 1'b1, 32'h300, 3'd1};

      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_req", 32'(bus.imem_req), 32'd0);
      chk("reset_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_count", 32'(bus.count), 32'd0);
      chk("reset_addr", bus.imem_addr, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      model_pc = 32'h0;
      for (int i = 0; i < 29; i++) begin
         drive(tv[i].rdy, tv[i].rv, tv[i].rpc);
         chk($sformatf("row%0d_req", i), 32'(bus.imem_req), 32'(tv[i].e_req));
         chk($sformatf("row%0d_addr", i), bus.imem_addr, tv[i].e_addr);
         chk($sformatf("row%0d_valid", i), 32'(bus.out_valid), 32'(tv[i].e_ov));
         chk($sformatf("row%0d_count", i), 32'(bus.count), 32'(tv[i].e_cnt));
         if (tv[i].e_ov) begin
            chk($sformatf("row%0d_pc", i), bus.out_pc, tv[i].e_pc);
            chk($sformatf("row%0d_pc_plus4", i), bus.out_pc_plus4, tv[i].e_pc + 32'd4);
         end
         sb_step();
         @(negedge clk);
      end

      for (int i = 0; i < 60; i++) begin
         drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) == 0),
               $urandom & 32'h0000_0FFF);
         chk("count_bound", 32'(bus.count <= 3'd4), 32'd1);
         sb_step();
         @(negedge clk);
      end

      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 32'h0);
         sb_step();
         if (i == 4) chk("req_before_reset", 32'(bus.imem_req), 32'd1);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_valid", 32'(bus.out_valid), 32'd0);
      chk("midreset_count", 32'(bus.count), 32'd0);
      chk("midreset_req", 32'(bus.imem_req), 32'd0);
      chk("midreset_addr", bus.imem_addr, 32'h0);
      @(negedge clk);
      sb_q.delete();
      model_pc = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 32'h0);
         if (i == 0) chk("post_reset_first_cycle_req", 32'(bus.imem_req), 32'd0);
         if (!seen && bus.out_valid) begin
            seen = 1'b1;
            chk("post_reset_first_pc", bus.out_pc, 32'h0);
         end
         sb_step();
         @(negedge clk);
      end
      chk("post_reset_output_seen", 32'(seen), 32'd1);

      chk("wrap_done", 32'(wrap_done), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      logic [31:0] exp_pc [4];
      logic [31:0] exp_p4 [4];
      int n;
      exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      exp_p4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
      n = 0;
      rst_w_n = 1'b0;
      bus_w.out_ready = 1'b1;
      bus_w.redirect_valid = 1'b0;
      bus_w.redirect_pc = '0;
      repeat (3) @(negedge clk);
      rst_w_n = 1'b1;
      for (int i = 0; i < 16 && n < 4; i++) begin
         @(negedge clk);
         #1;
         if (bus_w.out_valid) begin
            chk($sformatf("wrap_pc%0d", n), bus_w.out_pc, exp_pc[n]);
            chk($sformatf("wrap_pc_plus4_%0d", n), bus_w.out_pc_plus4, exp_p4[n]);
            chk($sformatf("wrap_inst%0d", n), bus_w.out_inst, inst_of(exp_pc[n]));
            n++;
         end
      end
      chk("wrap_entries", 32'(n), 32'd4);
      wrap_done = 1'b1;
   end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined core; replaces the bare PC register, PC+4 adder and PC mux of the single-cycle datapath.
- Owns the PC and issues requests to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions with their PCs in a DEPTH-entry queue toward decode (valid/ready handshake).
- Takes a single redirect input (branch/JAL target from execute) that flushes all in-flight and queued fetches.

Parameters:
XLEN, 32, PC/address width
ILEN, 32, instruction width
DEPTH, 4, fetch queue entries; power of two, >=2
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
imem_req  out  1  fetch request this cycle
imem_addr  out  XLEN  fetch address (= pc)
imem_rdata  in  ILEN  instruction data, valid the cycle after imem_req
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored, forced to 0
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  XLEN  PC of head instruction
out_pc_plus4  out  XLEN  out_pc + 4, modulo 2^XLEN
out_inst  out  ILEN  head instruction
count  out  $clog2(DEPTH)+1  occupied queue entries

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_PC; queue empty; count = 0; in-flight flag = 0.
  - imem_req = 0; out_valid = 0.
  - Outputs hold these values while rst_n = 0 and for the whole first cycle after release.
- Credit: pop = out_valid & out_ready; space = DEPTH - count - inflight + pop.
- imem_req = !redirect_valid & (space > 0); imem_addr = pc.
- On imem_req: pc <= pc + 4, wrapping modulo 2^XLEN (0xFFFF_FFFC -> 0); inflight <= 1 and the request PC is stored.
- When no request is issued: inflight <= 0.
- Cycle after a request: {stored pc, imem_rdata} pushed to queue tail at the clock edge, unless killed by redirect.
- Push and pop in the same cycle are both honoured; count unchanged.
- out_* driven combinationally from the queue head; no rdata-to-output bypass.
- Latency: request in cycle t -> out_valid in cycle t+2. Steady state with out_ready = 1 gives 1 instruction/cycle for any DEPTH >= 2.
- Backpressure (out_ready = 0): queue fills to DEPTH; requests stop once count + inflight = DEPTH. No data is ever dropped or overwritten.
- Redirect, cycle r (priority over everything):
  - queue cleared (count <= 0);
  - in-flight response arriving in cycle r discarded; inflight <= 0;
  - imem_req = 0;
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - A pop in cycle r is a valid handoff (decode owns that instruction and kills it itself).
  - Fetch of the target issues in r+1; first target out_valid in r+3.
- Back-to-back redirects: the latest wins; each restarts the r+3 timing.
- Reset asserted mid-operation: immediate return to reset state; in-flight data discarded.
- Queue pointers wrap modulo DEPTH; full/empty derived from count.

Decomposition:
- Package fetch_pkg:
  - RESET_PC default;
  - NOP constant 32'h0000_0013;
  - PC_STEP = 4;
  - packed fetch-entry typedef {pc, inst}.
- One sub-module: fetch_fifo.
  - Synchronous FIFO, DEPTH entries, with push, pop, flush, count, head read.
  - Flush has priority over push.
- PC/credit/in-flight logic stays in fetch_queue_unit.

Test Plan:
1. Reset release, out_ready = 1, imem returns addr as data -> imem_req in cycle 1 at 0x0; out_valid in cycle 3 with out_pc 0x0, out_pc_plus4 0x4; then one entry per cycle at 0x4, 0x8, ... with no bubbles.
2. DEPTH = 4, out_ready = 0 -> count reaches 4; imem_req low afterwards; raising out_ready drains 4 entries in order, then fetch resumes at 0x10 with no lost or duplicated PC.
3. redirect_valid in cycle r with redirect_pc = 0x0000_0103 while queue holds 3 entries -> count = 0 in r+1; imem_req in r+1 with addr 0x100; out_pc 0x100 first valid in r+3; no stale PC ever appears.
4. redirect_pc 0x200 in cycle r, then 0x300 in r+1 -> no 0x200 entry reaches the output; first output 0x300 in r+4.
5. RESET_PC = 32'hFFFF_FFF8 -> output PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_plus4 for FFFF_FFFC = 0.
6. rst_n pulsed low mid-stream with a request in flight -> out_valid = 0 and count = 0 immediately; after release the first output is RESET_PC.
